gpio_port_int: RTL
==================

GPIO_PORT_INT -- requirements
Module: gpio_port_int

Interface
REQ-001 The block SHALL have parameter BASE, default 16'h0200, giving the register block base address (word-aligned).
REQ-002 The block SHALL have parameter AUTO_CLR, default 0; when 1, the CLR pulse clears the highest-priority pending flag.
REQ-003 The block SHALL have port MCLK, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RSTn, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port MAB, input, 16 bits: memory address bus.
REQ-006 The block SHALL have port MDBwrite, input, 16 bits: write data.
REQ-007 The block SHALL have port MDBread, output, 16 bits: read data; 0 when no register is addressed (OR-combinable).
REQ-008 The block SHALL have port MW, input, 1 bit: write strobe.
REQ-009 The block SHALL have port BW, input, 1 bit: byte access.
REQ-010 The block SHALL have port PIN, input, 8 bits: asynchronous pad inputs.
REQ-011 The block SHALL have port POUT, output, 8 bits: output latch.
REQ-012 The block SHALL have port PDIR, output, 8 bits: direction (1 = output).
REQ-013 The block SHALL have port INT, output, 1 bit: interrupt request to the interrupt unit's module_int input.
REQ-014 The block SHALL have port CLR, input, 1 bit: acknowledge pulse from the interrupt unit's module_clr output.

Function
REQ-015 The register map SHALL be (offset, 8-bit unless noted): IN +00 (read-only), OUT +02, DIR +04, IV +0E (16-bit, read-only), IES +18, IE +1A, IFG +1C.
REQ-016 Reads SHALL be combinational from MAB: the addressed register is zero-extended onto MDBread; BW does not alter read data.
REQ-017 A write SHALL occur at the MCLK edge where MW=1 and MAB equals a register address; only MDBwrite[7:0] is stored, for both BW=0 and BW=1.
REQ-018 Writes to IN SHALL be ignored.
REQ-019 A write to IV SHALL clear all IFG bits.
REQ-020 PIN SHALL pass through a 2-flop synchronizer; IN shows the second stage.
REQ-021 Edge detection SHALL compare the second synchronizer stage against a third registered copy: IES bit 0 selects a rising edge, IES bit 1 selects a falling edge.
REQ-022 A detected selected edge SHALL set the matching IFG bit one cycle after the edge appears in the second stage, regardless of IE.
REQ-023 Writing IES SHALL NOT set IFG.
REQ-024 INT SHALL be combinational |(IFG & IE).
REQ-025 IV SHALL be 2*(n+1), where n is the lowest-indexed set bit of IFG & IE; IV SHALL be 0 when IFG & IE is 0 (bit 0 has the highest priority; range 0x02..0x10).
REQ-026 An IV read access SHALL be detected when MAB = BASE+0E with MW=0 and the previous-cycle MAB differs (first cycle of access only); that edge SHALL clear the IFG bit reported by IV.
REQ-027 Holding MAB on IV for multiple cycles SHALL clear only one flag.
REQ-028 If AUTO_CLR=1, CLR=1 SHALL clear the flag currently reported by IV; if AUTO_CLR=0, CLR SHALL be ignored.
REQ-029 When a hardware set and a clear (software write, IV read, CLR) hit the same IFG bit in the same cycle, the set SHALL win.
REQ-030 On a software IFG write, the new IFG value SHALL be MDBwrite[7:0] OR same-cycle hardware sets.
REQ-031 Multiple flags SHALL be serviced in priority order; each clear re-evaluates IV combinationally in the next cycle.

Reset
REQ-032 When RSTn=0 at an MCLK edge, the block SHALL clear OUT, DIR, IES, IE, IFG, all synchronizer stages, the edge-history flop and the previous-MAB register to 0.
REQ-033 After such a reset, POUT, PDIR and INT SHALL be 0 and IV SHALL read 0.
REQ-034 Reset mid-operation SHALL discard pending flags and in-flight edges.
REQ-035 No flag SHALL be set by the first post-reset comparison, because the history is 0 and only transitions count; a PIN already high SHALL NOT cause a rising-edge flag.

Verification
REQ-036 Scenario 1: IE=01, IES=00, PIN[0] 0->1 -> IFG=01 at the 3rd edge after the change; INT=1; IV=0002.
REQ-037 Scenario 2: IE=FF, IES=FF, PIN[5] and PIN[2] fall together -> IFG=24; the first IV read returns 0006 and leaves IFG=20; the second read returns 000C and leaves IFG=00; INT falls.
REQ-038 Scenario 3: IV address held 4 cycles with IFG=03 -> only bit 0 cleared, IFG=02.
REQ-039 Scenario 4: software writes IFG=00 in the same cycle that a rising edge on PIN[3] is detected (IES[3]=0) -> IFG=08.
REQ-040 Scenario 5: with IFG=80 and IE=00 -> INT=0 and IV=0000; writing IE=80 -> INT=1 and IV=0010; AUTO_CLR=1 with a CLR pulse -> IFG=00.
REQ-041 Scenario 6: OUT=A5 and DIR=0F written by word write at BASE+02/+04 -> POUT=A5 and PDIR=0F; RSTn low for 1 cycle -> both 00 and IFG=00.

Source files
------------

// File: rtl/gpio_port_int.sv
// gpio_port_int: 8-bit GPIO port with synchronized inputs, edge-triggered
// interrupt flags and a priority interrupt vector register.
module gpio_port_int #(
    parameter logic [15:0] BASE     = 16'h0200,
    parameter bit          AUTO_CLR = 1'b0
) (
    input  logic        MCLK,
    input  logic        RSTn,
    input  logic [15:0] MAB,
    input  logic [15:0] MDBwrite,
    output logic [15:0] MDBread,
    input  logic        MW,
    input  logic        BW,
    input  logic [7:0]  PIN,
    output logic [7:0]  POUT,
    output logic [7:0]  PDIR,
    output logic        INT,
    input  logic        CLR
);
    localparam logic [15:0] A_IN  = BASE;
    localparam logic [15:0] A_OUT = BASE + 16'h02;
    localparam logic [15:0] A_DIR = BASE + 16'h04;
    localparam logic [15:0] A_IV  = BASE + 16'h0E;
    localparam logic [15:0] A_IES = BASE + 16'h18;
    localparam logic [15:0] A_IE  = BASE + 16'h1A;
    localparam logic [15:0] A_IFG = BASE + 16'h1C;

    logic [7:0]  out_r, dir_r, ies, ie, ifg, s1, s2, hist;
    logic [7:0]  pend, iv_mask, rise, fall, hw_set, clr_mask, ifg_nxt;
    logic [15:0] prev_mab, iv;
    logic [2:0]  armed;
    logic        iv_rd;
    logic        unused_ok;

    assign unused_ok = ^{BW, MDBwrite[15:8]};
    assign pend      = ifg & ie;
    assign INT       = |pend;
    assign POUT      = out_r;
    assign PDIR      = dir_r;

    always_comb begin
        iv      = '0;
        iv_mask = '0;
        for (int i = 7; i >= 0; i--) begin
            if (pend[i]) begin
                iv      = 16'(2 * i + 2);
                iv_mask = 8'(1 << i);
            end
        end
    end

    // Edges count only once the history flop holds a real pad sample, so
    // a pad already high at reset release never looks like a rising edge.
    assign rise   = s2 & ~hist;
    assign fall   = ~s2 & hist;
    assign hw_set = armed[2] ? ((ies & fall) | (~ies & rise)) : 8'h00;

    assign iv_rd    = (MAB == A_IV) && !MW && (prev_mab != MAB);
    assign clr_mask = ((iv_rd || (AUTO_CLR && CLR)) ? iv_mask : 8'h00);
    assign ifg_nxt  = (MW && MAB == A_IFG) ? (MDBwrite[7:0] | hw_set) :
                      (MW && MAB == A_IV)  ? hw_set :
                      ((ifg & ~clr_mask) | hw_set);

    always_comb begin
        MDBread = (MAB == A_IN)  ? {8'h00, s2}    :
                  (MAB == A_OUT) ? {8'h00, out_r} :
                  (MAB == A_DIR) ? {8'h00, dir_r} :
                  (MAB == A_IV)  ? iv             :
                  (MAB == A_IES) ? {8'h00, ies}   :
                  (MAB == A_IE)  ? {8'h00, ie}    :
                  (MAB == A_IFG) ? {8'h00, ifg}   : 16'h0000;
    end

    always_ff @(posedge MCLK) begin
        if (!RSTn) begin
            out_r    <= '0;
            dir_r    <= '0;
            ies      <= '0;
            ie       <= '0;
            ifg      <= '0;
            s1       <= '0;
            s2       <= '0;
            hist     <= '0;
            prev_mab <= '0;
            armed    <= '0;
        end else begin
            s1       <= PIN;
            s2       <= s1;
            hist     <= s2;
            armed    <= {armed[1:0], 1'b1};
            prev_mab <= MAB;
            ifg      <= ifg_nxt;
            if (MW && MAB == A_OUT) out_r <= MDBwrite[7:0];
            if (MW && MAB == A_DIR) dir_r <= MDBwrite[7:0];
            if (MW && MAB == A_IES) ies   <= MDBwrite[7:0];
            if (MW && MAB == A_IE)  ie    <= MDBwrite[7:0];
        end
    end
endmodule
